// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle RV32I main FSM and its datapath/memory port.
// The controller takes the master view; the datapath takes the slave view.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       instr_done;
  logic       err;

  modport master (
    input  opcode, funct3, zero, lt, ltu, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           imm_src, alu_src_a, alu_src_b, alu_op, result_src, instr_done, err
  );

  modport slave (
    output opcode, funct3, zero, lt, ltu, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           imm_src, alu_src_a, alu_src_b, alu_op, result_src, instr_done, err
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback over one shared memory port, with a per-access wait timeout.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    START, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             limit_hit;

  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic z,
                                       input logic slt, input logic sltu);
    logic c;
    case (f3)
      3'b000:  c = z;
      3'b001:  c = !z;
      3'b100:  c = slt;
      3'b101:  c = !slt;
      3'b110:  c = sltu;
      3'b111:  c = !sltu;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // A wait cycle that would bring the count up to the limit is the last one tolerated.
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign limit_hit = TIMEOUT_EN && (cnt_inc == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.imm_src    = 3'b000;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.result_src = 2'b00;
    bus.instr_done = 1'b0;
    bus.err        = 1'b0;

    case (state_q)
      START: state_d = FETCH;

      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b10;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = DECODE;
        end else begin
          cnt_d = cnt_inc;
          if (limit_hit) state_d = ERROR;
        end
      end

      DECODE: begin
        // JAL needs its own immediate for the target; everything else precomputes a branch target.
        bus.imm_src   = (bus.opcode == OP_JAL) ? 3'b011 : 3'b010;
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXEC_R;
          OP_IALU:           state_d = EXEC_I;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default:           state_d = ERROR;
        endcase
      end

      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        if (bus.opcode == OP_STORE) begin
          bus.imm_src = 3'b001;
          state_d     = MEMWR;
        end else begin
          state_d     = MEMRD;
        end
      end

      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ready) begin
          state_d = MEMWB;
        end else begin
          cnt_d = cnt_inc;
          if (limit_hit) state_d = ERROR;
        end
      end

      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.result_src = 2'b01;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end

      MEMWR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end else begin
          cnt_d = cnt_inc;
          if (limit_hit) state_d = ERROR;
        end
      end

      EXEC_R: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
        state_d       = ALUWB;
      end

      EXEC_I: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
        state_d       = ALUWB;
      end

      ALUWB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end

      BRANCH: begin
        bus.alu_src_a  = 2'b10;
        bus.alu_op     = 2'b01;
        bus.instr_done = 1'b1;
        if (branch_f3_legal(bus.funct3)) begin
          bus.pc_write = branch_cond(bus.funct3, bus.zero, bus.lt, bus.ltu);
          state_d      = FETCH;
        end else begin
          state_d      = ERROR;
        end
      end

      JAL: begin
        bus.imm_src   = 3'b011;
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
        state_d       = ALUWB;
      end

      ERROR: bus.err = 1'b1;

      default: state_d = ERROR;
    endcase

    // Every wait state starts its access with a fresh count.
    if (state_d != state_q) cnt_d = '0;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-level bench for multicycle_ctrl: each instruction is expanded
// into its expected per-cycle control schedule and compared against the DUT outputs.
module tb_multicycle_ctrl;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [18:0] obs;
  assign obs = {bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.imm_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.result_src, bus.instr_done, bus.err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [18:0] ov(input int req, we, adr, irw, pcw, rw, imm,
                                     a, b, op, rs, done, e);
    return {1'(req), 1'(we), 1'(adr), 1'(irw), 1'(pcw), 1'(rw), 3'(imm),
            2'(a), 2'(b), 2'(op), 2'(rs), 1'(done), 1'(e)};
  endfunction

  function automatic logic [18:0] x_fetch(input int r);       return ov(1,0,0,r,r,0,0, 0,2,0,0,0,0); endfunction
  function automatic logic [18:0] x_decode(input int j);      return ov(0,0,0,0,0,0,j ? 3 : 2, 1,1,0,0,0,0); endfunction
  function automatic logic [18:0] x_memadr(input int st);     return ov(0,0,0,0,0,0,st ? 1 : 0, 2,1,0,0,0,0); endfunction
  function automatic logic [18:0] x_memrd();                  return ov(1,0,1,0,0,0,0, 0,0,0,0,0,0); endfunction
  function automatic logic [18:0] x_memwb();                  return ov(0,0,0,0,0,1,0, 0,0,0,1,1,0); endfunction
  function automatic logic [18:0] x_memwr(input int r);       return ov(1,1,1,0,0,0,0, 0,0,0,0,r,0); endfunction
  function automatic logic [18:0] x_exec(input int imm_b);    return ov(0,0,0,0,0,0,0, 2,imm_b,2,0,0,0); endfunction
  function automatic logic [18:0] x_aluwb();                  return ov(0,0,0,0,0,1,0, 0,0,0,0,1,0); endfunction
  function automatic logic [18:0] x_branch(input int t);      return ov(0,0,0,0,t,0,0, 2,0,1,0,1,0); endfunction
  function automatic logic [18:0] x_jal();                    return ov(0,0,0,0,1,0,3, 1,2,0,0,0,0); endfunction
  function automatic logic [18:0] x_err();                    return ov(0,0,0,0,0,0,0, 0,0,0,0,0,1); endfunction

  // Branch outcome from the RV32I definition of each branch mnemonic.
  function automatic int taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return int'(a == b);
      3'b001:  return int'(a != b);
      3'b100:  return int'($signed(a) <  $signed(b));
      3'b101:  return int'($signed(a) >= $signed(b));
      3'b110:  return int'(a <  b);
      3'b111:  return int'(a >= b);
      default: return 0;
    endcase
  endfunction

  task automatic step(input string tag, input bit rdy, input logic [18:0] want);
    bus.mem_ready = rdy;
    #1;
    chk(tag, 32'(obs), 32'(want));
    @(posedge clk);
    #2;
  endtask

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic reset_pulse(input string tag);
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({tag, "_async"}, 32'(obs), 32'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step({tag, "_start"}, rnd_bit(), ov(0,0,0,0,0,0,0,0,0,0,0,0,0));
  endtask

  task automatic run_instr(input int kind, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input int fw, input int mw);
    case (kind)
      K_LOAD:  bus.opcode = 7'b0000011;
      K_STORE: bus.opcode = 7'b0100011;
      K_R:     bus.opcode = 7'b0110011;
      K_I:     bus.opcode = 7'b0010011;
      K_BR:    bus.opcode = 7'b1100011;
      default: bus.opcode = 7'b1101111;
    endcase
    bus.funct3 = f3;
    bus.zero   = (a - b) == 32'd0;
    bus.lt     = $signed(a) < $signed(b);
    bus.ltu    = a < b;
    for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, x_fetch(0));
    step("fetch", 1'b1, x_fetch(1));
    step("decode", rnd_bit(), x_decode(int'(kind == K_JAL)));
    case (kind)
      K_LOAD: begin
        step("memadr_ld", rnd_bit(), x_memadr(0));
        for (int i = 0; i < mw; i++) step("memrd_wait", 1'b0, x_memrd());
        step("memrd", 1'b1, x_memrd());
        step("memwb", rnd_bit(), x_memwb());
      end
      K_STORE: begin
        step("memadr_st", rnd_bit(), x_memadr(1));
        for (int i = 0; i < mw; i++) step("memwr_wait", 1'b0, x_memwr(0));
        step("memwr", 1'b1, x_memwr(1));
      end
      K_R: begin
        step("exec_r", rnd_bit(), x_exec(0));
        step("aluwb_r", rnd_bit(), x_aluwb());
      end
      K_I: begin
        step("exec_i", rnd_bit(), x_exec(1));
        step("aluwb_i", rnd_bit(), x_aluwb());
      end
      K_BR: step("branch", rnd_bit(), x_branch(taken(f3, a, b)));
      default: begin
        step("jal", rnd_bit(), x_jal());
        step("aluwb_jal", rnd_bit(), x_aluwb());
      end
    endcase
  endtask

  initial begin
    logic [2:0]  br_f3 [6];
    logic [31:0] a, b;
    int          kind;
    logic [2:0]  f3;

    br_f3[0] = 3'b000; br_f3[1] = 3'b001; br_f3[2] = 3'b100;
    br_f3[3] = 3'b101; br_f3[4] = 3'b110; br_f3[5] = 3'b111;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.opcode = '0; bus.funct3 = '0; bus.zero = 1'b0; bus.lt = 1'b0;
    bus.ltu = 1'b0; bus.mem_ready = 1'b0;
    #1;
    chk("reset", 32'(obs), 32'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    step("start", 1'b1, ov(0,0,0,0,0,0,0,0,0,0,0,0,0));

    // Directed instruction flows.
    run_instr(K_R, 3'b000, 32'd5, 32'd7, 0, 0);
    run_instr(K_LOAD, 3'b010, 32'd0, 32'd0, 3, 2);
    run_instr(K_BR, 3'b000, 32'd9, 32'd9, 0, 0);
    run_instr(K_BR, 3'b000, 32'd9, 32'd8, 1, 0);
    run_instr(K_BR, 3'b111, 32'd1, 32'hFFFF_FFFF, 0, 0);
    run_instr(K_JAL, 3'b000, 32'd0, 32'd0, 0, 0);
    run_instr(K_STORE, 3'b010, 32'd0, 32'd0, 2, 3);

    for (int n = 0; n < 50; n++) begin
      kind = int'($urandom_range(0, 5));
      a    = $urandom;
      b    = ($urandom_range(0, 2) == 0) ? a : $urandom;
      f3   = (kind == K_BR) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      run_instr(kind, f3, a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Fetch that never completes: four waits reach the limit, then error is terminal.
    bus.opcode = 7'b0110011;
    for (int i = 0; i < 4; i++) step("to_fetch_wait", 1'b0, x_fetch(0));
    step("to_err", 1'b1, x_err());
    step("to_err_hold", 1'b1, x_err());
    reset_pulse("to_rst");

    bus.opcode = 7'b0110111;
    step("ill_fetch", 1'b1, x_fetch(1));
    step("ill_decode", 1'b0, x_decode(0));
    step("ill_err", rnd_bit(), x_err());
    reset_pulse("ill_rst");

    bus.opcode = 7'b1100011;
    bus.funct3 = 3'b010;
    bus.zero   = 1'b1;
    step("brf3_fetch", 1'b1, x_fetch(1));
    step("brf3_decode", 1'b0, x_decode(0));
    step("brf3_branch", rnd_bit(), x_branch(0));
    step("brf3_err", rnd_bit(), x_err());
    reset_pulse("brf3_rst");

    // Reset arriving while a store waits on memory.
    bus.opcode = 7'b0100011;
    step("abort_fetch", 1'b1, x_fetch(1));
    step("abort_decode", 1'b0, x_decode(0));
    step("abort_memadr", 1'b0, x_memadr(1));
    step("abort_memwr", 1'b0, x_memwr(0));
    reset_pulse("abort_rst");
    step("abort_refetch", 1'b0, x_fetch(0));
    step("abort_refetch2", 1'b1, x_fetch(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
